// File: rtl/read_edge_list.sv
// -----------------------------------------------------------------------------
// read_edge_list
//
// Pipeline stage that walks the edge list of one source vertex at a time. For
// every accepted vertex it issues one DRAM read per 64-bit edge record and
// emits one item per edge downstream, tagged with the registered source id and
// property. A vertex with zero out-degree is consumed without any memory
// access or output.
//
// Optional feature (compile-time macro EDGE_WEIGHT_EN):
//   defined   : o_weight carries mem_data[63:32] captured with the record.
//   undefined : o_weight is constant 0 and mem_data[63:32] is ignored.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   ready                   upstream vertex valid this cycle
//   i_src_id/i_src_prop     source vertex id and its fetched property
//   i_edge_ptr/i_edge_cnt   byte address of first edge record, out-degree
//   p_stall_can_accept      high while a vertex can be taken (IDLE)
//   mem_req/mem_addr        DRAM read request, held until complete
//   complete/mem_data       one-cycle DRAM response and edge record
//   n_stall_can_accept      downstream accepts the current item
//   o_valid, o_src_id, o_src_prop, o_dst_id, o_weight, o_last
//                           per-edge output item
// -----------------------------------------------------------------------------
module read_edge_list #(
  parameter int ADDR_W = 64,
  parameter int STRIDE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [31:0]       i_src_id,
  input  logic [63:0]       i_src_prop,
  input  logic [ADDR_W-1:0] i_edge_ptr,
  input  logic [31:0]       i_edge_cnt,
  output logic              p_stall_can_accept,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              complete,
  input  logic [63:0]       mem_data,
  input  logic              n_stall_can_accept,
  output logic              o_valid,
  output logic [31:0]       o_src_id,
  output logic [63:0]       o_src_prop,
  output logic [31:0]       o_dst_id,
  output logic [31:0]       o_weight,
  output logic              o_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_EMIT
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       src_id_q, src_id_d;
  logic [63:0]       src_prop_q, src_prop_d;
  // Running read address: starts at the edge pointer and advances by STRIDE
  // per edge, so it always equals edge_ptr + idx*STRIDE modulo 2^ADDR_W.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       idx_q, idx_d;
  logic [31:0]       dst_q, dst_d;
  logic [31:0]       idx_inc;
  logic              is_last;

  // The final-edge test is done at 32 bits so a degree of 0xFFFFFFFF exits at
  // idx = 0xFFFFFFFE without idx ever wrapping.
  assign idx_inc = idx_q + 32'd1;
  assign is_last = (idx_inc == cnt_q);

`ifdef EDGE_WEIGHT_EN
  logic [31:0] weight_q, weight_d;
`else
  logic unused_weight;
  assign unused_weight = ^mem_data[63:32];
`endif

  // NOTE: every next-state signal is given its hold value before the case
  // statement, so no path through the block leaves a signal unassigned and no
  // latch is inferred.
  always_comb begin
    state_d    = state_q;
    src_id_d   = src_id_q;
    src_prop_d = src_prop_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dst_d      = dst_q;
`ifdef EDGE_WEIGHT_EN
    weight_d   = weight_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          src_id_d   = i_src_id;
          src_prop_d = i_src_prop;
          addr_d     = i_edge_ptr;
          cnt_d      = i_edge_cnt;
          idx_d      = 32'd0;
          // Zero-degree vertices are consumed here, leaving us ready again.
          if (i_edge_cnt != 32'd0) state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (complete) begin
          dst_d    = mem_data[31:0];
`ifdef EDGE_WEIGHT_EN
          weight_d = mem_data[63:32];
`endif
          state_d  = S_EMIT;
        end
      end
      S_EMIT: begin
        if (n_stall_can_accept) begin
          if (is_last) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_inc;
            addr_d  = addr_q + ADDR_W'(STRIDE);
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_id_q   <= '0;
      src_prop_q <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      dst_q      <= '0;
`ifdef EDGE_WEIGHT_EN
      weight_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_id_q   <= src_id_d;
      src_prop_q <= src_prop_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dst_q      <= dst_d;
`ifdef EDGE_WEIGHT_EN
      weight_q   <= weight_d;
`endif
    end
  end

  // Handshake outputs depend only on registered state.
  assign p_stall_can_accept = (state_q == S_IDLE);
  assign mem_req            = (state_q == S_REQ);
  assign o_valid            = (state_q == S_EMIT);
  assign mem_addr           = addr_q;
  assign o_src_id           = src_id_q;
  assign o_src_prop         = src_prop_q;
  assign o_dst_id           = dst_q;
  assign o_last             = (state_q == S_EMIT) && is_last;
`ifdef EDGE_WEIGHT_EN
  assign o_weight           = weight_q;
`else
  assign o_weight           = 32'd0;
`endif

endmodule

// File: tb/tb_read_edge_list.sv
// -----------------------------------------------------------------------------
// tb_read_edge_list
//
// Directed bench for read_edge_list. An abstract model expands each accepted
// vertex into its list of expected reads and output items; a compare process
// checks handshakes, addresses and items against that model on every cycle,
// and directed tests pin specific literal values.
// -----------------------------------------------------------------------------
module tb_read_edge_list;
  localparam int ADDR_W = 64;
  localparam int STRIDE = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              ready;
  logic [31:0]       i_src_id;
  logic [63:0]       i_src_prop;
  logic [ADDR_W-1:0] i_edge_ptr;
  logic [31:0]       i_edge_cnt;
  logic              p_stall_can_accept;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              complete;
  logic [63:0]       mem_data;
  logic              n_stall_can_accept;
  logic              o_valid;
  logic [31:0]       o_src_id;
  logic [63:0]       o_src_prop;
  logic [31:0]       o_dst_id;
  logic [31:0]       o_weight;
  logic              o_last;

  read_edge_list #(.ADDR_W(ADDR_W), .STRIDE(STRIDE)) dut (
    .clk                (clk),
    .reset              (reset),
    .ready              (ready),
    .i_src_id           (i_src_id),
    .i_src_prop         (i_src_prop),
    .i_edge_ptr         (i_edge_ptr),
    .i_edge_cnt         (i_edge_cnt),
    .p_stall_can_accept (p_stall_can_accept),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .complete           (complete),
    .mem_data           (mem_data),
    .n_stall_can_accept (n_stall_can_accept),
    .o_valid            (o_valid),
    .o_src_id           (o_src_id),
    .o_src_prop         (o_src_prop),
    .o_dst_id           (o_dst_id),
    .o_weight           (o_weight),
    .o_last             (o_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] src;
    logic [63:0] prop;
    logic [31:0] dst;
    logic [31:0] wgt;
    logic        last;
  } item_t;

  item_t       exp_out[$];
  logic [63:0] exp_addr[$];

  logic [63:0] addr_log[$];
  int          valid_cyc_log[$];
  logic        last_log[$];
  logic [31:0] dst_log[$];
  logic [31:0] wgt_log[$];
  int          accepts = 0;
  int          cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  logic manual_mem = 1'b0;
  int   resp_delay = 0;
  int   wait_cnt   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory contents: one distinctive record, otherwise address-derived data.
  function automatic logic [63:0] rec(input logic [63:0] a);
    if (a == 64'h2000) return 64'h0000_0007_0000_002A;
    return {a[31:0] ^ 32'hA5A5_0000, 32'(a >> 3) + 32'd100};
  endfunction

  function automatic logic [31:0] exp_weight(input logic [63:0] r);
`ifdef EDGE_WEIGHT_EN
    return r[63:32];
`else
    return 32'd0;
`endif
  endfunction

  // Model: an accepted vertex becomes cnt reads and cnt output items; reads
  // and items retire on their handshakes.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_out.delete();
      exp_addr.delete();
    end else begin
      cyc++;
      if (ready && p_stall_can_accept) begin
        accepts++;
        for (int unsigned i = 0; i < i_edge_cnt; i++) begin
          logic [63:0] a;
          item_t it;
          a       = i_edge_ptr + 64'(i) * 64'(STRIDE);
          it.src  = i_src_id;
          it.prop = i_src_prop;
          it.dst  = rec(a)[31:0];
          it.wgt  = exp_weight(rec(a));
          it.last = (i + 1 == i_edge_cnt);
          exp_addr.push_back(a);
          exp_out.push_back(it);
        end
      end
      if (mem_req && complete && exp_addr.size() > 0) begin
        addr_log.push_back(mem_addr);
        void'(exp_addr.pop_front());
      end
      if (o_valid && n_stall_can_accept && exp_out.size() > 0) begin
        valid_cyc_log.push_back(cyc);
        last_log.push_back(o_last);
        dst_log.push_back(o_dst_id);
        wgt_log.push_back(o_weight);
        void'(exp_out.pop_front());
      end
    end
  end

  // Compare: a read is outstanding when reads and items are equal in number,
  // an item is on the output when one more item than reads remains.
  always @(negedge clk) begin
    if (!reset) begin
      logic exp_req, exp_val, exp_idle;
      exp_idle = (exp_out.size() == 0);
      exp_req  = (exp_addr.size() > 0) && (exp_addr.size() == exp_out.size());
      exp_val  = (exp_out.size() > 0) && (exp_out.size() == exp_addr.size() + 1);
      check("p_stall_can_accept", 64'(p_stall_can_accept), 64'(exp_idle));
      check("mem_req", 64'(mem_req), 64'(exp_req));
      check("o_valid", 64'(o_valid), 64'(exp_val));
      if (exp_req && mem_req) check("mem_addr", mem_addr, exp_addr[0]);
      if (exp_val && o_valid) begin
        check("o_src_id", 64'(o_src_id), 64'(exp_out[0].src));
        check("o_src_prop", o_src_prop, exp_out[0].prop);
        check("o_dst_id", 64'(o_dst_id), 64'(exp_out[0].dst));
        check("o_weight", 64'(o_weight), 64'(exp_out[0].wgt));
        check("o_last", 64'(o_last), 64'(exp_out[0].last));
      end
    end
  end

  // DRAM responder: answers a request after resp_delay waiting cycles.
  always @(negedge clk) begin
    if (!manual_mem) begin
      if (mem_req && !reset) begin
        if (wait_cnt >= resp_delay) begin
          complete = 1'b1;
          mem_data = rec(mem_addr);
          wait_cnt = 0;
        end else begin
          complete = 1'b0;
          wait_cnt++;
        end
      end else begin
        complete = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(p_stall_can_accept && exp_out.size() == 0 && exp_addr.size() == 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n < 500) n_pass++;
    else $display("FAIL idle_timeout: waited %0d cycles, limit 500", n);
  endtask

  task automatic send(input logic [31:0] id, input logic [63:0] prop,
                      input logic [63:0] ptr, input logic [31:0] cnt);
    i_src_id   = id;
    i_src_prop = prop;
    i_edge_ptr = ptr;
    i_edge_cnt = cnt;
    ready      = 1'b1;
    @(negedge clk);
    ready      = 1'b0;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    valid_cyc_log.delete();
    last_log.delete();
    dst_log.delete();
    wgt_log.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_o_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_o_src_id"}, 64'(o_src_id), 64'd0);
    check({tag, "_o_src_prop"}, o_src_prop, 64'd0);
    check({tag, "_o_dst_id"}, 64'(o_dst_id), 64'd0);
    check({tag, "_o_weight"}, 64'(o_weight), 64'd0);
    check({tag, "_o_last"}, 64'(o_last), 64'd0);
    check({tag, "_p_stall"}, 64'(p_stall_can_accept), 64'd1);
  endtask

  initial begin
    int a0;
    int n;
    reset              = 1'b1;
    ready              = 1'b0;
    i_src_id           = '0;
    i_src_prop         = '0;
    i_edge_ptr         = '0;
    i_edge_cnt         = '0;
    complete           = 1'b0;
    mem_data           = '0;
    n_stall_can_accept = 1'b1;

    // Reset values.
    #12;
    check_reset_values("reset");
    #5 reset = 1'b0;
    wait_idle();

    // Three-edge vertex, zero-latency memory, downstream always ready.
    clear_logs();
    send(32'd5, 64'hDEAD_BEEF_0000_0001, 64'h1000, 32'd3);
    wait_idle();
    check("t1_reads", 64'(addr_log.size()), 64'd3);
    if (addr_log.size() == 3) begin
      check("t1_addr0", addr_log[0], 64'h1000);
      check("t1_addr1", addr_log[1], 64'h1008);
      check("t1_addr2", addr_log[2], 64'h1010);
    end
    check("t1_items", 64'(valid_cyc_log.size()), 64'd3);
    if (valid_cyc_log.size() == 3) begin
      check("t1_gap01", 64'(valid_cyc_log[1] - valid_cyc_log[0]), 64'd2);
      check("t1_gap12", 64'(valid_cyc_log[2] - valid_cyc_log[1]), 64'd2);
      check("t1_last0", 64'(last_log[0]), 64'd0);
      check("t1_last1", 64'(last_log[1]), 64'd0);
      check("t1_last2", 64'(last_log[2]), 64'd1);
    end

    // Two zero-degree vertices on consecutive cycles.
    clear_logs();
    a0         = accepts;
    i_src_id   = 32'd10;
    i_edge_cnt = 32'd0;
    i_edge_ptr = 64'h9000;
    ready      = 1'b1;
    @(negedge clk);
    i_src_id   = 32'd11;
    @(negedge clk);
    ready      = 1'b0;
    @(negedge clk);
    check("t2_accepts", 64'(accepts - a0), 64'd2);
    check("t2_no_reads", 64'(addr_log.size()), 64'd0);
    check("t2_no_items", 64'(valid_cyc_log.size()), 64'd0);

    // Downstream stalls 4 cycles on the first of two edges.
    clear_logs();
    resp_delay         = 1;
    n_stall_can_accept = 1'b0;
    send(32'd7, 64'h0123_4567_89AB_CDEF, 64'h3000, 32'd2);
    n = 0;
    while (!o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t3_first_valid_seen", 64'(o_valid), 64'd1);
    repeat (4) @(negedge clk);
    check("t3_held_valid", 64'(o_valid), 64'd1);
    check("t3_held_dst", 64'(o_dst_id), 64'(rec(64'h3000)[31:0]));
    check("t3_no_second_req", 64'(mem_req), 64'd0);
    check("t3_reads_during_stall", 64'(addr_log.size()), 64'd1);
    n_stall_can_accept = 1'b1;
    wait_idle();
    check("t3_reads", 64'(addr_log.size()), 64'd2);
    if (addr_log.size() == 2) check("t3_addr1", addr_log[1], 64'h3008);
    resp_delay = 0;

    // Address wrap across the top of the address space.
    clear_logs();
    send(32'd9, 64'h1, 64'hFFFF_FFFF_FFFF_FFF8, 32'd2);
    wait_idle();
    check("t4_reads", 64'(addr_log.size()), 64'd2);
    if (addr_log.size() == 2) begin
      check("t4_addr0", addr_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
      check("t4_addr1", addr_log[1], 64'h0);
    end

    // Record field split.
    clear_logs();
    send(32'd12, 64'h2, 64'h2000, 32'd1);
    wait_idle();
    check("t5_items", 64'(dst_log.size()), 64'd1);
    if (dst_log.size() == 1) begin
      check("t5_dst", 64'(dst_log[0]), 64'd42);
`ifdef EDGE_WEIGHT_EN
      check("t5_weight", 64'(wgt_log[0]), 64'd7);
`else
      check("t5_weight", 64'(wgt_log[0]), 64'd0);
`endif
    end

    // Slow memory, several waiting cycles per read.
    clear_logs();
    resp_delay = 3;
    send(32'd20, 64'h3, 64'h4000, 32'd2);
    wait_idle();
    check("t6_items", 64'(valid_cyc_log.size()), 64'd2);
    resp_delay = 0;

    // Reset in REQ, then a late complete one cycle after deassertion.
    manual_mem = 1'b1;
    complete   = 1'b0;
    send(32'd30, 64'h4, 64'h5000, 32'd2);
    check("t7_in_req", 64'(mem_req), 64'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("t7_reset");
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    complete = 1'b1;
    mem_data = 64'h0000_0099_0000_0077;
    @(negedge clk);
    complete = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t7_no_valid", 64'(o_valid), 64'd0);
      check("t7_idle", 64'(p_stall_can_accept), 64'd1);
    end
    manual_mem = 1'b0;

    // Recovery after reset.
    clear_logs();
    send(32'd40, 64'h5, 64'h6000, 32'd1);
    wait_idle();
    check("t8_items", 64'(valid_cyc_log.size()), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/read_edge_list.md
# read_edge_list

Pipeline stage directly downstream of the source-property read stage in the graph-processing pipeline. Accepts one source vertex at a time (id, fetched property, edge-list pointer, out-degree), walks its edge list in DRAM one 64-bit record per read, and emits one item per edge to the next stage. It uses the same ready / complete / stall-can-accept handshake style as its neighbouring stages.

## Interface
Parameters:
- ADDR_W, 64, DRAM byte-address width
- STRIDE, 8, byte distance between consecutive edge records

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- ready  input  1  upstream item valid this cycle
- i_src_id  input  32  source vertex id
- i_src_prop  input  64  source property from previous stage
- i_edge_ptr  input  ADDR_W  byte address of first edge record
- i_edge_cnt  input  32  out-degree; 0 is legal
- p_stall_can_accept  output  1  high when an upstream item is taken this cycle if ready=1
- mem_req  output  1  DRAM read request, held until complete
- mem_addr  output  ADDR_W  read address, stable while mem_req=1
- complete  input  1  one-cycle DRAM response strobe
- mem_data  input  64  edge record, valid with complete; [31:0] dst id, [63:32] weight
- n_stall_can_accept  input  1  downstream accepts when high
- o_valid  output  1  output item valid
- o_src_id  output  32  registered source id
- o_src_prop  output  64  registered source property
- o_dst_id  output  32  destination id of current edge
- o_weight  output  32  edge weight (see Configuration)
- o_last  output  1  current edge is the vertex's final edge

## Operation
- States: IDLE, REQ, EMIT.
- IDLE: p_stall_can_accept=1. On ready=1: register src_id, src_prop, edge_ptr, edge_cnt; idx←0. If edge_cnt=0, stay in IDLE; no memory access and no output. Otherwise go to REQ.
- REQ: mem_req=1, mem_addr = edge_ptr + idx*STRIDE, truncated to ADDR_W (wraps modulo 2^ADDR_W). On complete=1: capture mem_data into o_dst_id/o_weight and go to EMIT.
- EMIT: o_valid=1, all o_* stable. o_last = (idx+1 == edge_cnt), compared at 32-bit width. On n_stall_can_accept=1: if o_last, go to IDLE; else idx←idx+1 and go to REQ.
- p_stall_can_accept=0 in REQ and EMIT.
- complete outside REQ is ignored; its data is discarded.
- edge_cnt=0xFFFFFFFF is legal; idx never overflows because exit happens at idx=edge_cnt-1.
- Reset, at any time including mid-vertex or mid-request: state→IDLE immediately. The outstanding request is abandoned and a late complete is ignored.

## Timing
- Reset values: o_valid=0, mem_req=0, mem_addr=0, o_src_id=0, o_src_prop=0, o_dst_id=0, o_weight=0, o_last=0. p_stall_can_accept=1.
- mem_req, p_stall_can_accept and o_valid are decoded from the registered state only; no combinational path from any input.
- Accept edge at cycle 0 → mem_req=1 in cycle 1. If complete arrives in cycle k ≥ 1 → o_valid=1 from cycle k+1.
- Edge handshake in cycle e → next mem_req in cycle e+1, or p_stall_can_accept=1 in cycle e+1 if that was the last edge.
- Peak throughput: one edge per 2 cycles. Zero-degree vertex: one accept per cycle back-to-back.

## Configuration
- EDGE_WEIGHT_EN defined: o_weight = mem_data[63:32], captured on complete.
- EDGE_WEIGHT_EN undefined: o_weight is constant 0 and mem_data[63:32] is unused. Addressing, stride and handshakes are unchanged.

## Test plan
- Reset → all outputs at reset values and p_stall_can_accept=1. Assert reset in REQ with complete arriving 1 cycle after deassertion → no o_valid, state IDLE.
- Vertex id=5, ptr=0x1000, cnt=3, complete same cycle as each mem_req, downstream always ready → mem_addr 0x1000, 0x1008, 0x1010; three o_valid pulses 2 cycles apart; o_last only on the third.
- cnt=0 on two consecutive cycles → both accepted, mem_req never asserted, o_valid never asserted.
- cnt=2, n_stall_can_accept low for 4 cycles in EMIT → o_* held stable, no second mem_req until the handshake.
- ptr=0xFFFF_FFFF_FFFF_FFF8, cnt=2 → second mem_addr=0x0 (wrap).
- mem_data=0x0000_0007_0000_002A → o_dst_id=42; o_weight=7 with EDGE_WEIGHT_EN, 0 without.
